// File: rtl/mem_wb_dm_pkg.sv
// Pipeline-wide memory-stage definitions: MemOp encoding, data-memory depth and byte-lane constants.
package mem_wb_dm_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LW   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LHU  = 4'd3,
    MEMOP_LB   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_SW   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SB   = 4'd8
  } memop_e;

  localparam int unsigned DM_DEPTH_WORDS = 3072;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LANES      = 4;
  localparam logic [3:0]  BE_WORD    = 4'b1111;
  localparam logic [3:0]  BE_HALF_LO = 4'b0011;
  localparam logic [3:0]  BE_HALF_HI = 4'b1100;
  localparam logic [3:0]  BE_BYTE0   = 4'b0001;

endpackage

// File: rtl/mem_wb_dm_lane_ext.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
module dm_lane_ext
  import mem_wb_dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_op,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    w_byte = i_word[BYTE_W*i_off +: BYTE_W];
    o_data = '0;
    case (memop_e'(i_op))
      MEMOP_LW:  o_data = i_word;
      MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_data = {16'h0000, w_half};
      MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_data = {24'h000000, w_byte};
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_dm.sv
// MEM stage: data-memory access with byte enables and the MEM->WB pipeline registers.
module mem_wb_dm
  import mem_wb_dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_C,
  input  logic [31:0] M_V2,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_PC8,
  input  logic [31:0] M_Instr,
  input  logic [3:0]  M_MemOp,
  input  logic        flush,
  output logic [31:0] W_C,
  output logic [31:0] W_DMRD,
  output logic [31:0] W_PC,
  output logic [31:0] W_PC8,
  output logic [31:0] W_Instr,
  output logic        W_AdEL,
  output logic        W_AdES
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_is_load;
  logic          w_is_store;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_ld_data;
  logic          w_ok;
  logic          w_we;

  always_comb begin
    w_off      = M_C - ADDR_BASE;
    w_idx      = w_off[AW+1:2];
    w_in_range = ({2'b00, w_off[31:2]} < 32'(DEPTH_WORDS));
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_aligned  = 1'b1;
    w_be       = '0;
    w_wdata    = M_V2;
    case (memop_e'(M_MemOp))
      MEMOP_LW: begin
        w_is_load = 1'b1;
        w_aligned = (w_off[1:0] == 2'b00);
      end
      MEMOP_LH, MEMOP_LHU: begin
        w_is_load = 1'b1;
        w_aligned = ~w_off[0];
      end
      MEMOP_LB, MEMOP_LBU: w_is_load = 1'b1;
      MEMOP_SW: begin
        w_is_store = 1'b1;
        w_aligned  = (w_off[1:0] == 2'b00);
        w_be       = BE_WORD;
      end
      MEMOP_SH: begin
        w_is_store = 1'b1;
        w_aligned  = ~w_off[0];
        w_be       = w_off[1] ? BE_HALF_HI : BE_HALF_LO;
        w_wdata    = {2{M_V2[15:0]}};
      end
      MEMOP_SB: begin
        w_is_store = 1'b1;
        w_be       = BE_BYTE0 << w_off[1:0];
        w_wdata    = {4{M_V2[7:0]}};
      end
      default: ;
    endcase
    w_ok      = w_in_range & w_aligned;
    w_we      = w_is_store & w_ok & ~flush;
    // Guard the read: indices past DEPTH_WORDS are representable in AW bits.
    w_rd_word = w_in_range ? r_mem[w_idx] : '0;
  end

  dm_lane_ext u_lane_ext (
    .i_word (w_rd_word),
    .i_off  (w_off[1:0]),
    .i_op   (M_MemOp),
    .o_data (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      for (int unsigned b = 0; b < LANES; b++)
        if (w_be[b]) r_mem[w_idx][BYTE_W*b +: BYTE_W] <= w_wdata[BYTE_W*b +: BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_C     <= '0;
      W_DMRD  <= '0;
      W_PC    <= '0;
      W_PC8   <= '0;
      W_Instr <= '0;
      W_AdEL  <= 1'b0;
      W_AdES  <= 1'b0;
    end else if (flush) begin
      W_C     <= '0;
      W_DMRD  <= '0;
      W_PC    <= '0;
      W_PC8   <= '0;
      W_Instr <= '0;
      W_AdEL  <= 1'b0;
      W_AdES  <= 1'b0;
    end else begin
      W_C     <= M_C;
      W_DMRD  <= (w_is_load & w_ok) ? w_ld_data : '0;
      W_PC    <= M_PC;
      W_PC8   <= M_PC8;
      W_Instr <= M_Instr;
      W_AdEL  <= w_is_load & ~w_ok;
      W_AdES  <= w_is_store & ~w_ok;
    end
  end

endmodule
